fetch_unit: RTL and testbench

- Instruction fetch stage that drives the synchronous-read instruction ROM and consumes its output.
- Keeps the program counter and issues one ROM word address per cycle.
- Pairs each returned word with its PC and hands the pair to decode over a valid/ready handshake.
- A 2-entry buffer absorbs the ROM's fixed 1-cycle read latency, so full throughput holds even under decode backpressure. Branch/jump redirects flush everything in flight.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, synchronous-ROM addressing and a 2-entry output buffer toward decode.
// Optional stall counter output enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter int          AWIDTH   = 12,
  parameter int          DWIDTH   = 32,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_qout,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DWIDTH-1:0] id_inst,
  output logic [31:0]       id_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic [31:0]       pc_q;
  logic              req_v;
  logic [31:0]       req_pc;
  logic              out_v;
  logic [DWIDTH-1:0] out_inst;
  logic [31:0]       out_pc;
  logic              skid_v;
  logic [DWIDTH-1:0] skid_inst;
  logic [31:0]       skid_pc;

  logic              fire;
  logic              redirect;
  logic              issue;
  logic [1:0]        occ;
  logic [31:0]       target;

  // Issue stage: occupancy counts out, skid and the word returning from the ROM
  always_comb begin
    fire     = out_v & id_ready;
    redirect = redirect_valid & !rst;
    target   = redirect_pc & ~32'h3;
    occ      = 2'(out_v) + 2'(skid_v) + 2'(req_v);
    issue    = !rst & ((occ < 2'd2) | fire);
    rom_addr = redirect ? target[AWIDTH+1:2] : pc_q[AWIDTH+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      req_v  <= 1'b0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (redirect) begin
      pc_q   <= target + 32'd4;
      req_v  <= 1'b1;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      req_v <= issue;
      if (issue) pc_q <= pc_q + 32'd4;
      if (fire && skid_v) begin
        out_v  <= 1'b1;
        skid_v <= req_v;
      end else if (!out_v || fire) begin
        out_v <= req_v;
      end else if (req_v) begin
        skid_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (redirect) begin
      req_pc <= target;
    end else if (issue) begin
      req_pc <= pc_q;
    end
  end

  // Landing stage: returning word goes to out when it is free, otherwise behind it in skid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst <= '0;
      out_pc   <= '0;
    end else if (!redirect) begin
      if (fire && skid_v) begin
        out_inst <= skid_inst;
        out_pc   <= skid_pc;
      end else if ((!out_v || fire) && req_v) begin
        out_inst <= rom_qout;
        out_pc   <= req_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect && req_v && ((fire && skid_v) || (out_v && !fire))) begin
      skid_inst <= rom_qout;
      skid_pc   <= req_pc;
    end
  end

  assign id_valid = out_v;
  assign id_inst  = out_inst;
  assign id_pc    = out_pc;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_v && !id_ready && (stall_q != 32'hFFFFFFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and 0x3FFC), each with a 1-cycle ROM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;

  logic [11:0] rom_addr;
  logic [31:0] rom_qout;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  logic [11:0] w_rom_addr;
  logic [31:0] w_rom_qout;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_id_valid;
  logic [31:0] w_id_inst;
  logic [31:0] w_id_pc;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] w_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ROM models: mem[n] = A0000000 + n, registered read
  always @(posedge clk) rom_qout   <= 32'hA0000000 + 32'(rom_addr);
  always @(posedge clk) w_rom_qout <= 32'hA0000000 + 32'(w_rom_addr);

  fetch_unit #(.AWIDTH(12), .DWIDTH(32), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_qout(rom_qout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  fetch_unit #(.AWIDTH(12), .DWIDTH(32), .RESET_PC(32'h00003FFC)) dut_w (
    .clk(clk), .rst(rst), .rom_addr(w_rom_addr), .rom_qout(w_rom_qout),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .id_valid(w_id_valid), .id_ready(id_ready), .id_inst(w_id_inst), .id_pc(w_id_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cnt(w_stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
    step(); step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", id_valid); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 00000000", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", id_pc); end
    checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    rst = 1'b0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL first_latency_valid got %b want 0", id_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, id_valid); end
      checks++; if (id_pc !== 32'(i * 4)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, id_pc, 32'(i * 4)); end
      checks++; if (id_inst !== 32'hA0000000 + 32'(i)) begin errors++; $display("FAIL stream_inst[%0d] got %h want %h", i, id_inst, 32'hA0000000 + 32'(i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(); step(); step(); step(); step();
    checks++; if (id_pc !== 32'd12) begin errors++; $display("FAIL bp_start_pc got %h want 0000000c", id_pc); end
    id_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, id_valid); end
      checks++; if (id_pc !== 32'd12) begin errors++; $display("FAIL bp_hold_pc[%0d] got %h want 0000000c", k, id_pc); end
      checks++; if (id_inst !== 32'hA0000003) begin errors++; $display("FAIL bp_hold_inst[%0d] got %h want a0000003", k, id_inst); end
      checks++; if (rom_addr !== 12'd5) begin errors++; $display("FAIL bp_rom_addr[%0d] got %0d want 5", k, rom_addr); end
    end
`ifdef FETCH_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL bp_stall_cnt got %0d want 5", stall_cnt); end
`endif
    id_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bp_resume_valid[%0d] got %b want 1", j, id_valid); end
      checks++; if (id_pc !== 32'd16 + 32'(j * 4)) begin errors++; $display("FAIL bp_resume_pc[%0d] got %h want %h", j, id_pc, 32'd16 + 32'(j * 4)); end
      checks++; if (id_inst !== 32'hA0000004 + 32'(j)) begin errors++; $display("FAIL bp_resume_inst[%0d] got %h want %h", j, id_inst, 32'hA0000004 + 32'(j)); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step(); step(); step();
    id_ready = 1'b0;
    step();
    checks++; if (id_pc !== 32'd4) begin errors++; $display("FAIL rd_pre_pc got %h want 00000004", id_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h00000103;
    #1;
    checks++; if (rom_addr !== 12'd64) begin errors++; $display("FAIL rd_rom_addr got %0d want 64", rom_addr); end
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_flush_valid got %b want 0", id_valid); end
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rd_target_valid got %b want 1", id_valid); end
    checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL rd_target_pc got %h want 00000100", id_pc); end
    checks++; if (id_inst !== 32'hA0000040) begin errors++; $display("FAIL rd_target_inst got %h want a0000040", id_inst); end
    step();
    checks++; if (id_pc !== 32'h104) begin errors++; $display("FAIL rd_next_pc got %h want 00000104", id_pc); end
    checks++; if (id_inst !== 32'hA0000041) begin errors++; $display("FAIL rd_next_inst got %h want a0000041", id_inst); end
  endtask

  task automatic test_wrap();
    rst = 1'b1; redirect_valid = 1'b0; id_ready = 1'b1;
    step(); step();
    checks++; if (w_rom_addr !== 12'd4095) begin errors++; $display("FAIL wrap_reset_addr got %0d want 4095", w_rom_addr); end
    rst = 1'b0;
    step();
    checks++; if (w_rom_addr !== 12'd0) begin errors++; $display("FAIL wrap_addr got %0d want 0", w_rom_addr); end
    step();
    checks++; if (w_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", w_id_valid); end
    checks++; if (w_id_pc !== 32'h3FFC) begin errors++; $display("FAIL wrap_pc0 got %h want 00003ffc", w_id_pc); end
    checks++; if (w_id_inst !== 32'hA0000FFF) begin errors++; $display("FAIL wrap_inst0 got %h want a0000fff", w_id_inst); end
    step();
    checks++; if (w_id_pc !== 32'h4000) begin errors++; $display("FAIL wrap_pc1 got %h want 00004000", w_id_pc); end
    checks++; if (w_id_inst !== 32'hA0000000) begin errors++; $display("FAIL wrap_inst1 got %h want a0000000", w_id_inst); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    step(); step(); step();
    id_ready = 1'b0;
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", id_valid); end
    rst = 1'b1; id_ready = 1'b1;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h want 00000000", id_pc); end
    rst = 1'b0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got %b want 0", id_valid); end
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid got %b want 1", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL mid_restart_pc got %h want 00000000", id_pc); end
    checks++; if (id_inst !== 32'hA0000000) begin errors++; $display("FAIL mid_restart_inst got %h want a0000000", id_inst); end
  endtask

  task automatic test_rst_redirect();
    do_reset();
    step(); step(); step();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00000200;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rr_valid got %b want 0", id_valid); end
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rr_latency_valid got %b want 0", id_valid); end
    step();
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rr_pc got %h want 00000000", id_pc); end
    checks++; if (id_inst !== 32'hA0000000) begin errors++; $display("FAIL rr_inst got %h want a0000000", id_inst); end
    step();
    checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL rr_next_pc got %h want 00000004", id_pc); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_rst_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
